// File: rtl/screen_arbiter.sv
// Round-robin arbiter sharing one screen_writer rectangle-fill engine between
// NUM_REQ drawing clients; latches the winner's rectangle and muxes its live colour.
//
// state   | meaning
// S_IDLE  | no job; pick next requester round-robin from owner+1
// S_START | one-cycle screen_start pulse; screen_done ignored
// S_BUSY  | writer drawing; wait for screen_done
// S_DONE  | one-cycle done pulse to owner; grant dropped on exit
module screen_arbiter #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3,
   parameter int NUM_REQ      = 3,
   parameter int OWNER_WIDTH  = 2
) (
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ*COLOUR_WIDTH-1:0] req_colour_i,
   input  logic [NUM_REQ*WIDTH-1:0]        req_x_min_i,
   input  logic [NUM_REQ*WIDTH-1:0]        req_y_min_i,
   input  logic [NUM_REQ*WIDTH-1:0]        req_x_range_i,
   input  logic [NUM_REQ*WIDTH-1:0]        req_y_range_i,
   output logic [NUM_REQ-1:0]              grant_o,
   output logic [NUM_REQ-1:0]              done_o,
   output logic                            busy_o,
   output logic [OWNER_WIDTH-1:0]          owner_o,
   output logic                            screen_start_o,
   output logic [COLOUR_WIDTH-1:0]         new_screen_colour_o,
   output logic [WIDTH-1:0]                screen_x_min_o,
   output logic [WIDTH-1:0]                screen_y_min_o,
   output logic [WIDTH-1:0]                screen_x_range_o,
   output logic [WIDTH-1:0]                screen_y_range_o,
   input  logic                            screen_done_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [OWNER_WIDTH-1:0] owner_q, owner_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [WIDTH-1:0]       x_min_q, x_min_d;
   logic [WIDTH-1:0]       y_min_q, y_min_d;
   logic [WIDTH-1:0]       x_range_q, x_range_d;
   logic [WIDTH-1:0]       y_range_q, y_range_d;

   logic [OWNER_WIDTH-1:0] pick_idx;
   logic [OWNER_WIDTH-1:0] cand;
   logic                   pick_vld;

   // Scan from lowest priority to highest so the nearest requester after owner wins.
   always_comb begin
      pick_idx = owner_q;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = OWNER_WIDTH'((int'(owner_q) + i) % NUM_REQ);
         if (req_i[cand]) begin
            pick_idx = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      x_min_d   = x_min_q;
      y_min_d   = y_min_q;
      x_range_d = x_range_q;
      y_range_d = y_range_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d   = S_START;
               owner_d   = pick_idx;
               grant_d   = NUM_REQ'(1) << pick_idx;
               x_min_d   = req_x_min_i[int'(pick_idx)*WIDTH +: WIDTH];
               y_min_d   = req_y_min_i[int'(pick_idx)*WIDTH +: WIDTH];
               x_range_d = req_x_range_i[int'(pick_idx)*WIDTH +: WIDTH];
               y_range_d = req_y_range_i[int'(pick_idx)*WIDTH +: WIDTH];
            end
         end
         // A zero-range rectangle can raise screen_done before the writer starts.
         S_START: state_d = S_BUSY;
         S_BUSY: begin
            if (screen_done_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         owner_q   <= OWNER_WIDTH'(NUM_REQ - 1);
         grant_q   <= '0;
         x_min_q   <= '0;
         y_min_q   <= '0;
         x_range_q <= '0;
         y_range_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         x_min_q   <= x_min_d;
         y_min_q   <= y_min_d;
         x_range_q <= x_range_d;
         y_range_q <= y_range_d;
      end
   end

   always_comb begin
      done_o = '0;
      if (state_q == S_DONE) begin
         done_o = grant_q;
      end
   end

   assign grant_o             = grant_q;
   assign busy_o              = (state_q != S_IDLE);
   assign owner_o             = owner_q;
   assign screen_start_o      = (state_q == S_START);
   assign new_screen_colour_o = req_colour_i[int'(owner_q)*COLOUR_WIDTH +: COLOUR_WIDTH];
   assign screen_x_min_o      = x_min_q;
   assign screen_y_min_o      = y_min_q;
   assign screen_x_range_o    = x_range_q;
   assign screen_y_range_o    = y_range_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Scoreboard bench for screen_arbiter with a behavioural screen_writer model
// that plots one pixel per cycle and pulses screen_done after the last one.
module tb_screen_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [8:0]  req_colour = '0;
   logic [23:0] xm = '0, ym = '0, xr = '0, yr = '0;
   logic        spur = 1'b0;

   logic [2:0]  grant, done;
   logic        busy, start;
   logic [1:0]  owner;
   logic [2:0]  colour;
   logic [7:0]  sx_min, sy_min, sx_range, sy_range;
   logic        sdone;

   logic        wdone = 1'b0, w_active = 1'b0;
   logic [7:0]  w_xc = '0, w_yc = '0;
   int          w_pix = 0;

   always #5 clk = ~clk;

   screen_arbiter dut (
      .clock_i             (clk),
      .reset_i             (rst),
      .req_i               (req),
      .req_colour_i        (req_colour),
      .req_x_min_i         (xm),
      .req_y_min_i         (ym),
      .req_x_range_i       (xr),
      .req_y_range_i       (yr),
      .grant_o             (grant),
      .done_o              (done),
      .busy_o              (busy),
      .owner_o             (owner),
      .screen_start_o      (start),
      .new_screen_colour_o (colour),
      .screen_x_min_o      (sx_min),
      .screen_y_min_o      (sy_min),
      .screen_x_range_o    (sx_range),
      .screen_y_range_o    (sy_range),
      .screen_done_i       (sdone)
   );

   assign sdone = wdone | spur;

   always @(posedge clk) begin
      if (rst) begin
         w_active <= 1'b0;
         wdone    <= 1'b0;
         w_pix    <= 0;
      end else begin
         wdone <= 1'b0;
         if (start) begin
            w_active <= 1'b1;
            w_xc     <= '0;
            w_yc     <= '0;
            w_pix    <= 0;
         end else if (w_active) begin
            w_pix <= w_pix + 1;
            if (w_xc == sx_range && w_yc == sy_range) begin
               w_active <= 1'b0;
               wdone    <= 1'b1;
            end else if (w_xc == sx_range) begin
               w_xc <= '0;
               w_yc <= w_yc + 8'd1;
            end else begin
               w_xc <= w_xc + 8'd1;
            end
         end
      end
   end

   typedef struct {
      int owner;
      int xm, ym, xr, yr;
      int pix;
      bit aborted;
   } job_t;

   job_t exp_q[$];
   job_t cur;
   bit   job_open = 1'b0;
   bit   chk_low  = 1'b0;
   logic prev_sd  = 1'b0;
   int   n_vec = 0, n_err = 0;
   int   left[3] = '{0, 0, 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_client(input int c, input logic [2:0] col, input logic [7:0] x0,
                             input logic [7:0] y0, input logic [7:0] xrg, input logic [7:0] yrg);
      req_colour[c*3 +: 3] = col;
      xm[c*8 +: 8] = x0;
      ym[c*8 +: 8] = y0;
      xr[c*8 +: 8] = xrg;
      yr[c*8 +: 8] = yrg;
   endtask

   task automatic push(input int c, input int x0, input int y0, input int xrg, input int yrg,
                       input int pix, input bit ab);
      job_t j;
      j.owner = c; j.xm = x0; j.ym = y0; j.xr = xrg; j.yr = yrg;
      j.pix = pix; j.aborted = ab;
      exp_q.push_back(j);
   endtask

   // Clients drop req once their remaining job count reaches zero.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (done[i] && left[i] > 0) begin
            left[i]--;
            if (left[i] == 0) req[i] = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && busy == 1'b0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle timeout: %0d jobs still expected after %0d cycles", exp_q.size(), budget);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (rst) begin
            if (job_open) begin
               check("abort_expected", 32'(cur.aborted), 32'd1);
               void'(exp_q.pop_front());
               job_open = 1'b0;
            end
            chk_low = 1'b0;
         end else begin
            if (chk_low) begin
               check("grant_clear", 32'(grant), 32'd0);
               check("busy_clear", 32'(busy), 32'd0);
               chk_low = 1'b0;
            end
            if (start) begin
               check("start_while_open", 32'(job_open), 32'd0);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_start: owner %0d with no job expected", owner);
               end else begin
                  cur = exp_q[0];
                  check("start_owner", 32'(owner), 32'(cur.owner));
                  check("start_grant", 32'(grant), 32'd1 << cur.owner);
                  check("start_x_min", 32'(sx_min), 32'(cur.xm));
                  check("start_y_min", 32'(sy_min), 32'(cur.ym));
                  check("start_x_range", 32'(sx_range), 32'(cur.xr));
                  check("start_y_range", 32'(sy_range), 32'(cur.yr));
                  job_open = 1'b1;
               end
            end else if (job_open) begin
               check("busy_in_job", 32'(busy), 32'd1);
               if (done != 3'b000) begin
                  check("done_vec", 32'(done), 32'd1 << cur.owner);
                  check("done_grant", 32'(grant), 32'd1 << cur.owner);
                  check("done_pixels", 32'(w_pix), 32'(cur.pix));
                  check("done_latency", 32'(prev_sd), 32'd1);
                  void'(exp_q.pop_front());
                  job_open = 1'b0;
                  chk_low  = 1'b1;
               end else begin
                  check("x_min_hold", 32'(sx_min), 32'(cur.xm));
                  check("colour_mux", 32'(colour), 32'(req_colour[cur.owner*3 +: 3]));
               end
            end else if (done != 3'b000) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_done: done %b with no open job", done);
            end
         end
         prev_sd = sdone;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and a single job from client 0
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_owner", 32'(owner), 32'd2);
      check("rst_x_min", 32'(sx_min), 32'd0);
      set_client(0, 3'b001, 8'd10, 8'd20, 8'd3, 8'd1);
      push(0, 10, 20, 3, 1, 8, 1'b0);
      left[0] = 1;
      req = 3'b001;
      tick();
      check("t1_grant", 32'(grant), 32'b001);
      check("t1_start", 32'(start), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      tick();
      check("t1_start_pulse", 32'(start), 32'd0);
      check("t1_x_min", 32'(sx_min), 32'd10);
      check("t1_y_min", 32'(sy_min), 32'd20);
      wait_idle(200);

      // All three requesting from reset: order 0,1,2,0,1
      rst = 1'b1;
      req = 3'b111;
      set_client(0, 3'b001, 8'd10, 8'd20, 8'd1, 8'd0);
      set_client(1, 3'b010, 8'd30, 8'd40, 8'd0, 8'd1);
      set_client(2, 3'b100, 8'd50, 8'd60, 8'd1, 8'd1);
      push(0, 10, 20, 1, 0, 2, 1'b0);
      push(1, 30, 40, 0, 1, 2, 1'b0);
      push(2, 50, 60, 1, 1, 4, 1'b0);
      push(0, 10, 20, 1, 0, 2, 1'b0);
      push(1, 30, 40, 0, 1, 2, 1'b0);
      left = '{2, 2, 1};
      repeat (2) tick();
      rst = 1'b0;
      wait_idle(400);
      check("t2_req_dropped", 32'(req), 32'd0);

      // Zero-range job with a spurious screen_done during S_START
      set_client(1, 3'b011, 8'd7, 8'd9, 8'd0, 8'd0);
      push(1, 7, 9, 0, 0, 1, 1'b0);
      left[1] = 1;
      req = 3'b010;
      tick();
      check("t3_start", 32'(start), 32'd1);
      spur = 1'b1;
      tick();
      spur = 1'b0;
      wait_idle(100);

      // Parameters frozen at grant; colour follows the client live
      set_client(2, 3'b100, 8'd5, 8'd1, 8'd2, 8'd2);
      push(2, 5, 1, 2, 2, 9, 1'b0);
      left[2] = 1;
      req = 3'b100;
      tick();
      check("t4_grant", 32'(grant), 32'b100);
      tick();
      xm[16 +: 8] = 8'd50;
      for (int k = 0; k < 40 && busy; k++) begin
         req_colour[6 +: 3] = (k % 2 == 1) ? 3'b010 : 3'b100;
         tick();
      end
      wait_idle(100);
      check("t4_x_min_after", 32'(sx_min), 32'd5);

      // Reset during S_BUSY aborts the job without a done pulse
      set_client(0, 3'b101, 8'd3, 8'd3, 8'd5, 8'd5);
      push(0, 3, 3, 5, 5, 36, 1'b1);
      left[0] = 1;
      req = 3'b001;
      tick();
      repeat (4) tick();
      check("t5_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      req = 3'b000;
      left[0] = 0;
      tick();
      check("t5_grant", 32'(grant), 32'd0);
      check("t5_start", 32'(start), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_owner", 32'(owner), 32'd2);
      rst = 1'b0;
      set_client(1, 3'b010, 8'd4, 8'd4, 8'd1, 8'd0);
      set_client(2, 3'b110, 8'd8, 8'd8, 8'd0, 8'd0);
      push(1, 4, 4, 1, 0, 2, 1'b0);
      push(2, 8, 8, 0, 0, 1, 1'b0);
      left[1] = 1;
      left[2] = 1;
      req = 3'b110;
      tick();
      check("t5_first_grant", 32'(grant), 32'b010);
      wait_idle(200);

      // Client 0 re-requests but client 2 goes ahead of it
      set_client(0, 3'b001, 8'd11, 8'd12, 8'd1, 8'd1);
      set_client(2, 3'b011, 8'd13, 8'd14, 8'd0, 8'd1);
      push(0, 11, 12, 1, 1, 4, 1'b0);
      push(2, 13, 14, 0, 1, 2, 1'b0);
      push(0, 11, 12, 1, 1, 4, 1'b0);
      left[0] = 2;
      req[0] = 1'b1;
      tick();
      check("t6_grant0", 32'(grant), 32'b001);
      left[2] = 1;
      req[2] = 1'b1;
      wait_idle(300);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/screen_arbiter.md
Name: screen_arbiter

Overview:
Shares one screen_writer rectangle-fill engine between NUM_REQ drawing clients (e.g. background clear, horizon, HUD).
- Round-robin arbitration over client requests.
- Latches the winning client's rectangle parameters and pulses screen_start.
- Muxes the owner's live colour through to the writer.
- Returns a one-cycle done pulse to the owner when screen_done is seen.
- Sits between the flight-display logic clients and screen_writer.

Parameters:
WIDTH, 8, coordinate/range width (matches screen_writer WIDTH)
COLOUR_WIDTH, 3, colour width (matches screen_writer COLOUR_WIDTH)
NUM_REQ, 3, number of requesting clients (2..4)
OWNER_WIDTH, 2, width of owner index; must satisfy 2**OWNER_WIDTH >= NUM_REQ

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-client request level; held high until that client's done pulse
req_colour  in  NUM_REQ*COLOUR_WIDTH  per-client live colour, client i at bits [i*COLOUR_WIDTH +: COLOUR_WIDTH]
req_x_min  in  NUM_REQ*WIDTH  per-client rectangle x origin, packed as req_colour
req_y_min  in  NUM_REQ*WIDTH  per-client rectangle y origin
req_x_range  in  NUM_REQ*WIDTH  per-client x extent (screen_writer semantics)
req_y_range  in  NUM_REQ*WIDTH  per-client y extent
grant  out  NUM_REQ  one-hot, registered; high for owner from grant cycle through done cycle
done  out  NUM_REQ  one-hot, one-cycle pulse to owner at completion
busy  out  1  high whenever state != S_IDLE
owner  out  OWNER_WIDTH  index of current/last owner
screen_start  out  1  to screen_writer
new_screen_colour  out  COLOUR_WIDTH  to screen_writer
screen_x_min, screen_y_min  out  WIDTH each  to screen_writer, registered
screen_x_range, screen_y_range  out  WIDTH each  to screen_writer, registered
screen_done  in  1  from screen_writer

Behaviour:
- Reset (synchronous, any state) forces:
  - state = S_IDLE; grant = 0, done = 0, busy = 0, screen_start = 0.
  - screen_* parameter registers = 0.
  - owner = NUM_REQ-1, so client 0 has first priority.
  - The writer shares this reset, so a draw in progress is aborted. No done pulse is issued for the aborted job.
- States:
  - S_IDLE: if req != 0, select the first set bit searching from owner+1 upward, modulo NUM_REQ. On that edge: owner <= k, grant[k] <= 1, latch client k's x_min/y_min/x_range/y_range into screen_* registers; go to S_START. If req == 0, stay in S_IDLE.
  - S_START: screen_start = 1 for exactly this one cycle (decoded from state). screen_done is ignored here, because a zero-range rectangle can present screen_done while the writer is still idle. Go to S_BUSY unconditionally.
  - S_BUSY: screen_start = 0. On screen_done = 1, go to S_DONE. Otherwise stay; there is no timeout.
  - S_DONE: done[owner] = 1 for this cycle only. grant[owner] is still high. On exit: grant <= 0, go to S_IDLE.
- Latency:
  - req rising in an idle cycle T → grant and S_START in cycle T+1, screen_start high in T+1.
  - Completion: screen_done seen in cycle D → done pulse in D+1, grant low and S_IDLE in D+2.
  - Earliest next grant is D+3.
- Colour: new_screen_colour is a combinational mux of req_colour[owner]. Clients may compute colour per pixel from the writer's screen_x/screen_y during S_BUSY.
- Rectangle parameters: sampled only at the grant edge. Later changes by the client are ignored for that job.
- Fairness:
  - owner advances only on a grant.
  - A client that keeps req high after its done pulse is eligible again, but at lowest priority.
  - A lone requester may be granted back-to-back.
- Requests that drop before being granted are simply not served. Dropping req while granted has no effect; the job runs to completion.
- Simultaneous req and screen_done in S_IDLE or S_START: screen_done is ignored.
- Out-of-range owner values, possible only if NUM_REQ < 2**OWNER_WIDTH, are never produced.

Test Plan:
1. Reset, then req=3'b001 with client 0 x_min=10, y_min=20, x_range=3, y_range=1 → grant=001 next cycle; screen_start is a single-cycle pulse; screen_x_min=10, screen_y_min=20; writer plots 8 pixels; done=001 for one cycle; busy returns to 0.
2. req=3'b111 held continuously from reset → grant order 0,1,2,0,1 with one done pulse each, and no job starts before the previous done pulse.
3. Client 1 issues a zero-range job (x_range=0, y_range=0) → exactly 1 pixel plotted, done[1] pulses once, and the spurious screen_done during S_START does not end the job early.
4. Client 2 changes req_x_min from 5 to 50 one cycle after grant → screen_x_min stays 5 for the entire job. Client 2 colour toggles 3'b100/3'b010 mid-job → new_screen_colour tracks it each cycle.
5. Reset asserted mid-S_BUSY → next cycle grant=0, screen_start=0, busy=0, no done pulse; a subsequent req=3'b110 grants client 1 first.
6. Client 0 holds req high past its done pulse while client 2 raises req → client 2 is granted next, then client 0.
